// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-deep valid/ready holding register.
//
// The line is brought through a 2-flop synchronizer. A down-counter bit timer
// finds the middle of each bit, where the FSM takes one sample. Received bytes
// go to rx_data/rx_valid. Stop-bit and overrun errors are flagged.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit. parity_err pulses on a mismatch. Without the
// macro the receiver is 8N1 only and parity_err is tied low.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset_n     asynchronous active-low reset
//   RS232_Rx    serial line, idle high, asynchronous to clk
//   rx_ready    consumer accepts rx_data when rx_valid & rx_ready
//   rx_data     received byte, LSB received first
//   rx_valid    rx_data holds an unconsumed byte
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     sticky: a byte was dropped while rx_valid was high
//   parity_err  one-cycle pulse: parity mismatch (0 without UART_RX_PARITY_EN)
//   busy        receiver is not idle
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       RS232_Rx,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StStart   = 3'd1;
   localparam logic [2:0] StData    = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] StParity  = 3'd3;
`endif
   localparam logic [2:0] StStop    = 3'd4;
   localparam logic [2:0] StBrkWait = 3'd5;

   logic            rx_meta_q, rx_s_q;
   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;
   logic            perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
   logic            par_q, par_d;
`endif
   logic            tick;

   assign tick = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = ovr_q;
      perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
`endif

      // Handshake first; a delivery in the same cycle overrides it below.
      if (valid_q && rx_ready) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (!rx_s_q) begin
               cnt_d   = HalfLoad;
               state_d = StStart;
            end
         end
         StStart: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!rx_s_q) begin
               cnt_d   = FullLoad;
               idx_d   = 3'd0;
               state_d = StData;
            end else begin
               // Start bit gone by mid-bit: a glitch, not a frame.
               state_d = StIdle;
            end
         end
         StData: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shift_d = {rx_s_q, shift_q[7:1]};
               cnt_d   = FullLoad;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               par_d   = rx_s_q;
               cnt_d   = FullLoad;
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else if (rx_s_q) begin
               if (!valid_q || rx_ready) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
`ifdef UART_RX_PARITY_EN
               perr_d = ^shift_q ^ par_q;
`endif
               state_d = StIdle;
            end else begin
               ferr_d  = 1'b1;
               state_d = StBrkWait;
            end
         end
         StBrkWait: begin
            // Hold off until the line returns high so a break cannot retrigger.
            if (rx_s_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         rx_meta_q <= RS232_Rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
         perr_q    <= perr_d;
`ifdef UART_RX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign parity_err = perr_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Each phase lays out a line waveform and a rx_ready pattern per cycle. From the
// frame timing it works out when each stop bit is sampled and when busy must be
// high. A per-cycle model of the holding register is checked against the DUT.
module tb_uart_rx;

   localparam int N = 104;
   localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
   localparam bit PAR_EN = 1'b1;
`else
   localparam int NB = 10;
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int MAXC = 16384;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       RS232_Rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;
   logic       busy;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(N)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .RS232_Rx   (RS232_Rx),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err),
      .busy       (busy)
   );

   // Per-cycle stimulus and expectations for the current phase.
   bit         line_a  [MAXC];
   bit         ready_a [MAXC];
   bit         busy_a  [MAXC];
   int         ev_a    [MAXC];  // 1: good stop sampled, 2: bad stop sampled
   logic [7:0] evb_a   [MAXC];
   bit         evp_a   [MAXC];

   int checks = 0;
   int failures = 0;
   int phase_id = 0;

   // Holding-register model.
   bit         m_valid;
   logic [7:0] m_data;
   bit         m_ovr;

   // Per-phase observations.
   int         n_valid, n_ferr, n_busy, n_perr;
   logic [7:0] last_data;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic clear_phase();
      for (int c = 0; c < MAXC; c++) begin
         line_a[c]  = 1'b1;
         ready_a[c] = 1'b0;
         busy_a[c]  = 1'b0;
         ev_a[c]    = 0;
         evb_a[c]   = 8'h00;
         evp_a[c]   = 1'b0;
      end
   endtask

   // Frame starting (start bit driven) at cycle c0; returns first cycle the line is idle again.
   task automatic add_frame(input int c0, input logic [7:0] b, input bit stop_ok,
                            input int hold, input bit par, output int e);
      bit bits [NB];
      int s;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
      if (PAR_EN) bits[9] = par;
      bits[NB-1] = stop_ok;
      for (int k = 0; k < NB; k++)
         for (int c = c0 + k * N; c < c0 + (k + 1) * N; c++) line_a[c] = bits[k];
      e = c0 + NB * N + (stop_ok ? 0 : hold);
      for (int c = c0 + NB * N; c < e; c++) line_a[c] = 1'b0;
      // Two sync stages plus one FSM edge, half a bit, then NB-1 whole bits.
      s = c0 + 3 + H + (NB - 1) * N;
      ev_a[s]  = stop_ok ? 1 : 2;
      evb_a[s] = b;
      evp_a[s] = PAR_EN && stop_ok && ((^b) ^ par);
      for (int c = c0 + 3; c <= (stop_ok ? s - 1 : e + 2); c++) busy_a[c] = 1'b1;
   endtask

   task automatic add_glitch(input int c0, input int len);
      for (int c = c0; c < c0 + len; c++) line_a[c] = 1'b0;
      for (int c = c0 + 3; c <= c0 + 2 + H; c++) busy_a[c] = 1'b1;
   endtask

   task automatic run_phase(input int len);
      n_valid = 0; n_ferr = 0; n_busy = 0; n_perr = 0;
      phase_id++;
      for (int c = 0; c < len; c++) begin
         logic [12:0] got, exp;
         @(posedge clk);
         #1;
         if (m_valid && rx_ready) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
         end
         if (ev_a[c] == 1) begin
            if (!m_valid) begin
               m_data  = evb_a[c];
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end
         got = {busy, rx_valid, rx_data, frame_err, overrun, parity_err};
         exp = {busy_a[c], m_valid, m_data, ev_a[c] == 2, m_ovr, evp_a[c]};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL cycle phase=%0d c=%0d got busy=%b valid=%b data=%h ferr=%b ovr=%b perr=%b exp busy=%b valid=%b data=%h ferr=%b ovr=%b perr=%b",
                     phase_id, c, got[12], got[11], got[10:3], got[2], got[1], got[0],
                     exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
         end
         if (rx_valid === 1'b1) begin
            n_valid++;
            last_data = rx_data;
         end
         if (frame_err === 1'b1) n_ferr++;
         if (busy === 1'b1) n_busy++;
         if (parity_err === 1'b1) n_perr++;
         RS232_Rx = line_a[c];
         rx_ready = ready_a[c];
      end
   endtask

   task automatic fill_ready(input int len, input int pct);
      for (int c = 0; c < len; c++) ready_a[c] = ($urandom_range(0, 99) < pct);
   endtask

   task automatic check_reset_values(input string name);
      check(name, {rx_valid, rx_data, frame_err, overrun, parity_err, busy}, 13'h0000);
   endtask

   initial begin
      int e1, e2, c, gap;
      int pcts [4];
      pcts = '{100, 60, 10, 0};
      reset_n = 1'b0; RS232_Rx = 1'b1; rx_ready = 1'b0;
      m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0; last_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset_state");
      @(negedge clk);
      reset_n = 1'b1;

      // Single byte with the consumer always ready.
      clear_phase();
      add_frame(2, 8'h56, 1'b1, 0, 1'b0, e1);
      fill_ready(e1 + 20, 100);
      run_phase(e1 + 20);
      check("t1_valid_cycles", n_valid, 1);
      check("t1_data", last_data, 8'h56);
      check("t1_busy_cycles", n_busy, PAR_EN ? 1092 : 988);
      check("t1_ferr_pulses", n_ferr, 0);
      check("t1_overrun", overrun, 1'b0);

      // Short low pulse is rejected at mid start bit.
      clear_phase();
      add_glitch(2, 20);
      run_phase(2 + H + 20);
      check("t2_busy_cycles", n_busy, 52);
      check("t2_valid_cycles", n_valid, 0);
      check("t2_idle_after", busy, 1'b0);

      // Bad stop bit, long break, then a good byte.
      clear_phase();
      add_frame(2, 8'hA5, 1'b0, 500, 1'b0, e1);
      add_frame(e1 + 10, 8'h3C, 1'b1, 0, 1'b0, e2);
      fill_ready(e2 + 20, 100);
      run_phase(e2 + 20);
      check("t3_ferr_pulses", n_ferr, 1);
      check("t3_valid_cycles", n_valid, 1);
      check("t3_data", last_data, 8'h3C);

      // Back-to-back bytes with nobody consuming.
      clear_phase();
      add_frame(2, 8'h11, 1'b1, 0, 1'b0, e1);
      add_frame(e1, 8'h22, 1'b1, 0, 1'b0, e2);
      run_phase(e2 + 10);
      check("t4_data_kept", rx_data, 8'h11);
      check("t4_overrun", overrun, 1'b1);
      check("t4_valid", rx_valid, 1'b1);
      clear_phase();
      ready_a[0] = 1'b1;
      run_phase(4);
      check("t4_valid_cleared", rx_valid, 1'b0);
      check("t4_overrun_cleared", overrun, 1'b0);

      // Reset in the middle of data bit 4, then a clean frame.
      clear_phase();
      add_frame(2, 8'h56, 1'b1, 0, 1'b0, e1);
      fill_ready(e1, 100);
      run_phase(2 + 5 * N + H - 10);
      check("t5_busy_before_reset", busy, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_values("t5_reset_midframe");
      m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0;
      RS232_Rx = 1'b1; rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      clear_phase();
      add_frame(2, 8'h56, 1'b1, 0, 1'b0, e1);
      fill_ready(e1 + 20, 100);
      run_phase(e1 + 20);
      check("t5_valid_cycles", n_valid, 1);
      check("t5_data", last_data, 8'h56);

`ifdef UART_RX_PARITY_EN
      clear_phase();
      add_frame(2, 8'h56, 1'b1, 0, 1'b0, e1);
      add_frame(e1 + 5, 8'h56, 1'b1, 0, 1'b1, e2);
      fill_ready(e2 + 20, 100);
      run_phase(e2 + 20);
      check("t6_perr_pulses", n_perr, 1);
      check("t6_valid_cycles", n_valid, 2);
      check("t6_data", last_data, 8'h56);
`endif

      // Random mix of good frames, framing errors, glitches and consumer rates.
      for (int p = 0; p < 4; p++) begin
         clear_phase();
         c = 2;
         for (int f = 0; f < 8; f++) begin
            int kind;
            kind = $urandom_range(0, 9);
            gap  = $urandom_range(0, 40);
            if (kind < 2) begin
               add_glitch(c, $urandom_range(1, H - 3));
               c = c + H + 5 + gap;
            end else if (kind < 4) begin
               add_frame(c, 8'($urandom), 1'b0, $urandom_range(0, 200), 1'($urandom), e1);
               c = e1 + 5 + gap;
            end else begin
               add_frame(c, 8'($urandom), 1'b1, 0, 1'($urandom), e1);
               c = e1 + gap;
            end
         end
         fill_ready(c + 20, pcts[p]);
         run_phase(c + 20);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
